// File: rtl/hc4_pkg.sv
`default_nettype none
// ============================================================================
// Package : hc4_pkg
// Shared HC4 constants: address/instruction widths, fetch FSM encoding and
// jump opcode / condition codes used by the core, the fetch unit and benches.
// Rev 1.0 - initial release
// ============================================================================
package hc4_pkg;

   localparam int HC4_ADDR_W  = 12;
   localparam int HC4_INSTR_W = 8;

   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t FETCH_IDLE  = 2'd0;
   localparam fetch_state_t FETCH_REQ   = 2'd1;
   localparam fetch_state_t FETCH_DRAIN = 2'd2;

   localparam logic [2:0] HC4_OP_JUMP = 3'b111;

   localparam logic [2:0] HC4_CC_JP  = 3'b000;
   localparam logic [2:0] HC4_CC_JC  = 3'b001;
   localparam logic [2:0] HC4_CC_JNC = 3'b010;
   localparam logic [2:0] HC4_CC_JZ  = 3'b100;
   localparam logic [2:0] HC4_CC_JNZ = 3'b101;

endpackage
`default_nettype wire

// File: rtl/hc4_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : hc4_fetch_fifo
// DEPTH x WIDTH synchronous prefetch FIFO; flush beats push and pop.
// Rev 1.0 - initial release
// ============================================================================
module hc4_fetch_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 20,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_CNT);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/hc4_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : hc4_fetch_unit
// HC4 instruction fetch: req/ack program memory, prefetch FIFO, valid/ready
// to decode, redirect flush. Option macro: HC4_FETCH_BYPASS_EN.
// Rev 1.0 - initial release
// ============================================================================
module hc4_fetch_unit
   import hc4_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = HC4_ADDR_W,
   parameter int INSTR_W = HC4_INSTR_W
) (
   input  logic               clk,
   input  logic               nReset,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata
);

   localparam int            CW        = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   fetch_state_t              state_q, state_d;
   logic [ADDR_W-1:0]         fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;

   logic [ADDR_W+INSTR_W-1:0] fifo_rdata;
   logic [CW-1:0]             fifo_count;
   logic                      fifo_empty;
   logic                      fifo_full;
   logic                      fifo_push;
   logic                      fifo_pop;
   logic                      ack_req;
   logic                      bypass;
   logic                      bypass_take;
   logic [CW-1:0]             count_after;

   assign ack_req = (state_q == FETCH_REQ) && mem_ack;

`ifdef HC4_FETCH_BYPASS_EN
   assign bypass = fifo_empty && ack_req && !redirect;
`else
   assign bypass = 1'b0;
`endif

   assign bypass_take = bypass && instr_ready;
   assign fifo_push   = ack_req && !redirect && !bypass_take;
   assign fifo_pop    = !fifo_empty && instr_ready && !redirect;
   assign count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

   hc4_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + INSTR_W)
   ) u_fifo (
      .clk    (clk),
      .nReset (nReset),
      .flush  (redirect),
      .push   (fifo_push),
      .wdata  ({fetch_pc_q, mem_rdata}),
      .pop    (fifo_pop),
      .rdata  (fifo_rdata),
      .count  (fifo_count),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;
      case (state_q)
         FETCH_IDLE: begin
            if (!redirect && !fifo_full) begin
               state_d    = FETCH_REQ;
               mem_addr_d = fetch_pc_q;
            end
         end
         FETCH_REQ: begin
            if (mem_ack) begin
               if (redirect) begin
                  state_d = FETCH_IDLE;
               end else begin
                  fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                  if (count_after < DEPTH_CNT) mem_addr_d = fetch_pc_q + ADDR_W'(1);
                  else                         state_d    = FETCH_IDLE;
               end
            end else if (redirect) begin
               state_d = FETCH_DRAIN;
            end
         end
         // The outstanding request cannot be aborted; its data is dropped on ack.
         FETCH_DRAIN: begin
            if (mem_ack) state_d = FETCH_IDLE;
         end
         default: state_d = FETCH_IDLE;
      endcase
      if (redirect) fetch_pc_d = redirect_pc;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q    <= FETCH_IDLE;
         fetch_pc_q <= '0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign mem_req  = (state_q != FETCH_IDLE);
   assign mem_addr = mem_addr_q;

   always_comb begin
      instr_valid = 1'b0;
      instr       = '0;
      instr_pc    = '0;
      if (!fifo_empty) begin
         instr_valid        = 1'b1;
         {instr_pc, instr}  = fifo_rdata;
      end else if (bypass) begin
         instr_valid = 1'b1;
         instr       = mem_rdata;
         instr_pc    = fetch_pc_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hc4_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_hc4_fetch_unit
// Self-checking bench for hc4_fetch_unit: directed vector table, reset and
// randomized phases against a stream-level reference model.
// Rev 1.0 - initial release
// ============================================================================
module tb_hc4_fetch_unit;
   import hc4_pkg::*;

   localparam int DEPTH = 4;
`ifdef HC4_FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk         = 1'b0;
   logic        nReset      = 1'b0;
   logic        redirect    = 1'b0;
   logic [11:0] redirect_pc = '0;
   logic        instr_ready = 1'b0;
   logic        mem_ack     = 1'b0;
   logic [7:0]  mem_rdata   = '0;
   logic        instr_valid;
   logic [7:0]  instr;
   logic [11:0] instr_pc;
   logic        mem_req;
   logic [11:0] mem_addr;

   int checks = 0;
   int errors = 0;
   bit rom_ident = 1'b0;

   always #5 clk = ~clk;

   hc4_fetch_unit #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .nReset      (nReset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rom(input logic [11:0] a);
      return rom_ident ? a[7:0] : (a[7:0] ^ {a[3:0], a[11:8]});
   endfunction

   typedef struct packed {
      logic        rdy;
      logic        red;
      logic [11:0] rpc;
      logic        ack;
      logic [7:0]  rd;
      logic        ev;
      logic [7:0]  ei;
      logic [11:0] ep;
      logic        er;
      logic [11:0] ea;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rdy, input logic red, input logic [11:0] rpc,
                      input logic ack, input logic [7:0] rd, input logic ev,
                      input logic [7:0] ei, input logic [11:0] ep,
                      input logic er, input logic [11:0] ea);
      vec_t v;
      v.rdy = rdy; v.red = red; v.rpc = rpc; v.ack = ack; v.rd = rd;
      v.ev = ev; v.ei = ei; v.ep = ep; v.er = er; v.ea = ea;
      tbl.push_back(v);
   endtask

   task automatic idle_inputs();
      redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      nReset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      nReset = 1'b1;
   endtask

   task automatic run_phase(input string nm, input int ncyc, input int maxw,
                            input int rdy_pct, input int red_pct, input bit ident,
                            input bit tput, input int min_deliv);
      logic [11:0] exp_pc, exp_fetch, hold;
      int  occ, wt, delivered;
      bit  busy, stale, ack_good, fire, ev, push_m, pop_m;
      exp_pc = '0; exp_fetch = '0; hold = '0;
      occ = 0; wt = 0; delivered = 0; busy = 1'b0; stale = 1'b0;
      rom_ident = ident;
      do_reset();
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (mem_req && !busy) begin
            busy = 1'b1;
            hold = mem_addr;
            wt   = int'($urandom_range(maxw, 0));
            check({nm, " issue_room"}, 64'(occ < DEPTH), 64'(1));
            check({nm, " issue_addr"}, 64'(mem_addr), 64'(exp_fetch));
         end else if (mem_req && busy) begin
            check({nm, " addr_stable"}, 64'(mem_addr), 64'(hold));
         end else if (busy) begin
            check({nm, " req_held"}, 64'(mem_req), 64'(1));
            busy = 1'b0;
         end
         mem_ack = busy && (wt == 0);
         if (busy && wt != 0) wt--;
         mem_rdata   = mem_ack ? (stale ? ~rom(hold) : rom(hold)) : 8'($urandom);
         instr_ready = ($urandom_range(99, 0) < rdy_pct);
         redirect    = ($urandom_range(99, 0) < red_pct);
         redirect_pc = ($urandom_range(3, 0) == 0) ? 12'hFFD + 12'($urandom_range(2, 0))
                                                    : 12'($urandom);
         #1;
         ack_good = mem_ack && !stale && !redirect;
         ev       = (occ != 0) || (BYP && ack_good);
         check({nm, " valid"}, 64'(instr_valid), 64'(ev));
         if (tput && c >= 2) check({nm, " tput"}, 64'(instr_valid), 64'(1));
         fire = ev && instr_ready && !redirect;
         if (fire) begin
            check({nm, " pc"}, 64'(instr_pc), 64'(exp_pc));
            check({nm, " data"}, 64'(instr), 64'(rom(exp_pc)));
            exp_pc = exp_pc + 12'd1;
            delivered++;
         end
         if (redirect) begin
            occ = 0;
            exp_pc = redirect_pc;
            exp_fetch = redirect_pc;
         end else begin
            push_m = ack_good && !(BYP && occ == 0 && instr_ready);
            pop_m  = fire && occ != 0;
            if (ack_good) exp_fetch = exp_fetch + 12'd1;
            occ = occ + int'(push_m) - int'(pop_m);
         end
         if (mem_ack) begin
            busy = 1'b0;
            stale = 1'b0;
         end else if (redirect && busy) begin
            stale = 1'b1;
         end
      end
      check({nm, " progress"}, 64'(delivered >= min_deliv), 64'(1));
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got no_finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] act, exp;

      // rdy red rpc ack rd | ev ei ep | er ea
      add(0,0,12'h000,1,8'h10, BYP, BYP?8'h10:8'h00, 12'h000, 1,12'h000);
      add(0,0,12'h000,1,8'h11, 1, 8'h10, 12'h000, 1,12'h001);
      add(0,0,12'h000,1,8'h12, 1, 8'h10, 12'h000, 1,12'h002);
      add(0,0,12'h000,1,8'h13, 1, 8'h10, 12'h000, 1,12'h003);
      add(0,0,12'h000,0,8'h00, 1, 8'h10, 12'h000, 0,12'h000);
      add(1,0,12'h000,0,8'h00, 1, 8'h10, 12'h000, 0,12'h000);
      add(1,0,12'h000,0,8'h00, 1, 8'h11, 12'h001, 0,12'h000);
      add(1,1,12'h123,1,8'h14, 1, 8'h12, 12'h002, 1,12'h004);
      add(1,0,12'h000,0,8'h00, 0, 8'h00, 12'h000, 0,12'h000);
      add(1,0,12'h000,1,8'h77, BYP, BYP?8'h77:8'h00, BYP?12'h123:12'h000, 1,12'h123);
      add(1,0,12'h000,0,8'h00, !BYP, BYP?8'h00:8'h77, BYP?12'h000:12'h123, 1,12'h124);
      add(1,1,12'hFFE,0,8'h00, 0, 8'h00, 12'h000, 1,12'h124);
      add(1,0,12'h000,0,8'h00, 0, 8'h00, 12'h000, 1,12'h124);
      add(1,0,12'h000,1,8'hAA, 0, 8'h00, 12'h000, 1,12'h124);
      add(1,0,12'h000,0,8'h00, 0, 8'h00, 12'h000, 0,12'h000);
      add(1,0,12'h000,1,8'h5E, BYP, BYP?8'h5E:8'h00, BYP?12'hFFE:12'h000, 1,12'hFFE);
      add(1,0,12'h000,1,8'h5F, 1, BYP?8'h5F:8'h5E, BYP?12'hFFF:12'hFFE, 1,12'hFFF);
      add(1,0,12'h000,0,8'h00, !BYP, BYP?8'h00:8'h5F, BYP?12'h000:12'hFFF, 1,12'h000);
      add(1,0,12'h000,1,8'h60, BYP, BYP?8'h60:8'h00, 12'h000, 1,12'h000);

      repeat (3) @(negedge clk);
      nReset = 1'b1;
      foreach (tbl[i]) begin
         @(negedge clk);
         instr_ready = tbl[i].rdy;
         redirect    = tbl[i].red;
         redirect_pc = tbl[i].rpc;
         mem_ack     = tbl[i].ack;
         mem_rdata   = tbl[i].rd;
         #1;
         act = 64'({instr_valid, instr, instr_pc, mem_req, tbl[i].er ? mem_addr : 12'h000});
         exp = 64'({tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].er, tbl[i].ea});
         check($sformatf("vec%0d", i), act, exp);
      end

      // Reset asserted while a request at 0x001 is outstanding.
      @(negedge clk);
      idle_inputs();
      nReset = 1'b0;
      #1;
      check("rst_req",   64'(mem_req),     64'(0));
      check("rst_valid", 64'(instr_valid), 64'(0));
      check("rst_addr",  64'(mem_addr),    64'(0));
      check("rst_instr", 64'(instr),       64'(0));
      check("rst_pc",    64'(instr_pc),    64'(0));
      repeat (2) @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      #1;
      check("rel_req",  64'(mem_req),  64'(1));
      check("rel_addr", 64'(mem_addr), 64'(0));

      run_phase("stream", 40,   0, 100, 0, 1'b1, 1'b1, 38);
      run_phase("random", 3000, 2, 70,  5, 1'b0, 1'b0, 300);
      run_phase("bp",     600,  1, 15,  2, 1'b0, 1'b0, 30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
